// File: rtl/key_pkg.sv
// ---------------------------------------------------------------------------
// key_pkg
//   Shared definitions for the multi-channel push-button debouncer.
//   - rpt_state_e   : auto-repeat state per channel (IDLE / DELAY / REPEAT)
//   - ms_to_cycles  : converts a millisecond interval to clock cycles
//   - clog2         : ceiling log2, used to size the per-channel counters
//   - max3          : largest of three cycle counts
// ---------------------------------------------------------------------------
package key_pkg;

    typedef enum logic [1:0] {
        RPT_IDLE   = 2'd0,
        RPT_DELAY  = 2'd1,
        RPT_REPEAT = 2'd2
    } rpt_state_e;

    // Integer-kHz conversion: truncating the frequency first keeps the
    // product inside 32 bits for any realistic clock and interval.
    function automatic int unsigned ms_to_cycles(input int unsigned freq_hz,
                                                 input int unsigned ms);
        return (freq_hz / 1000) * ms;
    endfunction

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned r;
        r = 0;
        while ((64'd1 << r) < 64'(value)) begin
            r++;
        end
        return r;
    endfunction

    function automatic int unsigned max3(input int unsigned a,
                                         input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return m;
    endfunction

endpackage : key_pkg

// File: rtl/key_debounce_ch.sv
// ---------------------------------------------------------------------------
// key_debounce_ch
//   One push-button channel: 2-flop synchroniser, polarity normalisation,
//   stability-counter debounce, registered press/release edge pulses and an
//   auto-repeat state machine.
//
// Ports
//   clk_i        system clock
//   rst_i        asynchronous active-high reset
//   key_i        raw button input, asynchronous to clk_i
//   repeat_en_i  auto-repeat enable for this channel
//   level_o      debounced state, 1 = pressed
//   press_o      1-cycle pulse on the first pressed cycle
//   release_o    1-cycle pulse on the first released cycle
//   repeat_o     1-cycle auto-repeat pulse while held
// ---------------------------------------------------------------------------
module key_debounce_ch
    import key_pkg::*;
#(
    parameter int unsigned DB_CYC     = 5,
    parameter int unsigned RD_CYC     = 20,
    parameter int unsigned RR_CYC     = 8,
    parameter int unsigned CNT_W      = 6,
    parameter bit          ACTIVE_LOW = 1'b1
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic key_i,
    input  logic repeat_en_i,
    output logic level_o,
    output logic press_o,
    output logic release_o,
    output logic repeat_o
);

    localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DB_CYC - 1);
    localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(RD_CYC - 1);
    localparam logic [CNT_W-1:0] RR_LAST = CNT_W'(RR_CYC - 1);

    // Raw pin level that corresponds to "released".
    localparam logic RAW_RELEASED = ACTIVE_LOW;

    logic             sync1_q;
    logic             sync2_q;
    logic             sample;
    logic             level_q;
    logic             level_d;
    logic [CNT_W-1:0] db_cnt_q;
    logic [CNT_W-1:0] db_cnt_d;
    logic             press_q;
    logic             release_q;
    logic             repeat_q;
    logic             rise;
    logic             fall;
    rpt_state_e       state_q;
    logic [CNT_W-1:0] rp_cnt_q;

    // Normalised synchronised sample: 1 = pressed.
    assign sample = ACTIVE_LOW ? ~sync2_q : sync2_q;

    // Stability filter: any sample matching the current level restarts the
    // count, so only an uninterrupted run of DB_CYC differing samples flips it.
    always_comb begin
        level_d  = level_q;
        db_cnt_d = '0;
        if (sample != level_q) begin
            if (db_cnt_q == DB_LAST) begin
                level_d = sample;
            end else begin
                db_cnt_d = db_cnt_q + CNT_W'(1);
            end
        end
    end

    assign rise = level_d & ~level_q;
    assign fall = ~level_d & level_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync1_q   <= RAW_RELEASED;
            sync2_q   <= RAW_RELEASED;
            level_q   <= 1'b0;
            db_cnt_q  <= '0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            sync1_q   <= key_i;
            sync2_q   <= sync1_q;
            level_q   <= level_d;
            db_cnt_q  <= db_cnt_d;
            press_q   <= rise;
            release_q <= fall;
        end
    end

    // Auto-repeat FSM. It looks at the next-cycle level (level_d) so that
    // DELAY starts in the same edge that raises press_o, making the first
    // repeat land exactly RD_CYC cycles after the press, and so that a
    // release always wins over a repeat due in the release cycle.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= RPT_IDLE;
            rp_cnt_q <= '0;
            repeat_q <= 1'b0;
        end else begin
            repeat_q <= 1'b0;
            if (!level_d || !repeat_en_i) begin
                state_q  <= RPT_IDLE;
                rp_cnt_q <= '0;
            end else begin
                case (state_q)
                    RPT_IDLE: begin
                        rp_cnt_q <= '0;
                        if (rise) begin
                            state_q <= RPT_DELAY;
                        end
                    end
                    RPT_DELAY: begin
                        if (rp_cnt_q == RD_LAST) begin
                            repeat_q <= 1'b1;
                            state_q  <= RPT_REPEAT;
                            rp_cnt_q <= '0;
                        end else begin
                            rp_cnt_q <= rp_cnt_q + CNT_W'(1);
                        end
                    end
                    RPT_REPEAT: begin
                        if (rp_cnt_q == RR_LAST) begin
                            repeat_q <= 1'b1;
                            rp_cnt_q <= '0;
                        end else begin
                            rp_cnt_q <= rp_cnt_q + CNT_W'(1);
                        end
                    end
                    default: begin
                        state_q  <= RPT_IDLE;
                        rp_cnt_q <= '0;
                    end
                endcase
            end
        end
    end

    assign level_o   = level_q;
    assign press_o   = press_q;
    assign release_o = release_q;
    assign repeat_o  = repeat_q;

endmodule : key_debounce_ch

// File: rtl/key_debounce_multi.sv
// ---------------------------------------------------------------------------
// key_debounce_multi
//   N-channel push-button debouncer with press / release / auto-repeat
//   events. Each channel is an independent key_debounce_ch instance.
//
// Ports
//   clk          system clock
//   rst          asynchronous active-high reset
//   key_in       raw button inputs (asynchronous to clk)
//   repeat_en    per-channel auto-repeat enable
//   key_level    debounced state, 1 = pressed
//   key_press    1-cycle pulse when a channel becomes pressed
//   key_release  1-cycle pulse when a channel becomes released
//   key_repeat   1-cycle auto-repeat pulse while held
// ---------------------------------------------------------------------------
module key_debounce_multi
    import key_pkg::*;
#(
    parameter int unsigned NUM_KEYS        = 2,
    parameter int unsigned CLK_FREQ_HZ     = 50000000,
    parameter int unsigned DEBOUNCE_MS     = 20,
    parameter int unsigned REPEAT_DELAY_MS = 500,
    parameter int unsigned REPEAT_RATE_MS  = 100,
    parameter int unsigned ACTIVE_LOW      = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_KEYS-1:0] key_in,
    input  logic [NUM_KEYS-1:0] repeat_en,
    output logic [NUM_KEYS-1:0] key_level,
    output logic [NUM_KEYS-1:0] key_press,
    output logic [NUM_KEYS-1:0] key_release,
    output logic [NUM_KEYS-1:0] key_repeat
);

    localparam int unsigned DB_CYC = ms_to_cycles(CLK_FREQ_HZ, DEBOUNCE_MS);
    localparam int unsigned RD_CYC = ms_to_cycles(CLK_FREQ_HZ, REPEAT_DELAY_MS);
    localparam int unsigned RR_CYC = ms_to_cycles(CLK_FREQ_HZ, REPEAT_RATE_MS);
    localparam int unsigned CNT_W  = clog2(max3(DB_CYC, RD_CYC, RR_CYC)) + 1;

    if (NUM_KEYS < 1 || NUM_KEYS > 16) begin : g_bad_num_keys
        $error("key_debounce_multi: NUM_KEYS must be in 1..16");
    end
    if (DB_CYC < 2) begin : g_bad_db
        $error("key_debounce_multi: debounce interval shorter than 2 cycles");
    end
    if (RD_CYC < 2) begin : g_bad_rd
        $error("key_debounce_multi: repeat delay shorter than 2 cycles");
    end
    if (RR_CYC < 2) begin : g_bad_rr
        $error("key_debounce_multi: repeat rate shorter than 2 cycles");
    end

    for (genvar k = 0; k < NUM_KEYS; k++) begin : g_ch
        key_debounce_ch #(
            .DB_CYC     (DB_CYC),
            .RD_CYC     (RD_CYC),
            .RR_CYC     (RR_CYC),
            .CNT_W      (CNT_W),
            .ACTIVE_LOW (ACTIVE_LOW != 0)
        ) u_ch (
            .clk_i       (clk),
            .rst_i       (rst),
            .key_i       (key_in[k]),
            .repeat_en_i (repeat_en[k]),
            .level_o     (key_level[k]),
            .press_o     (key_press[k]),
            .release_o   (key_release[k]),
            .repeat_o    (key_repeat[k])
        );
    end

endmodule : key_debounce_multi
